// File: rtl/sha2_unrolled_core.sv
// SHA-256/SHA-224 compression core applying UNROLL rounds per clock, with a
// 16-word sliding message schedule that produces UNROLL new words per edge.
module sha2_unrolled_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         mode,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha2_unrolled_core: UNROLL must be 1, 2 or 4");
  end

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUNDS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [5:0] T_STEP = 6'(UNROLL);
  localparam logic [5:0] T_LAST = 6'(64 - UNROLL);

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    return K_ROM[idx];
  endfunction

  logic [1:0]  state;
  logic [5:0]  t_reg;
  logic        mode_reg;
  logic [31:0] h_reg  [8];
  logic [31:0] st_reg [8];
  logic [31:0] w_reg  [16];

  logic [31:0] w_ext  [16+UNROLL];
  logic [31:0] st_rnd [UNROLL+1][8];
  logic [31:0] t1_c   [UNROLL];
  logic [31:0] t2_c   [UNROLL];

  // Combinational cascade: schedule extension, then UNROLL chained rounds
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = w_reg[i];
    for (int j = 0; j < UNROLL; j++)
      w_ext[16+j] = small_sigma1(w_ext[14+j]) + w_ext[9+j]
                  + small_sigma0(w_ext[1+j]) + w_ext[j];
    for (int k = 0; k < 8; k++) st_rnd[0][k] = st_reg[k];
    for (int i = 0; i < UNROLL; i++) begin
      t1_c[i] = st_rnd[i][7] + big_sigma1(st_rnd[i][4])
              + ((st_rnd[i][4] & st_rnd[i][5]) ^ (~st_rnd[i][4] & st_rnd[i][6]))
              + k_rom(t_reg + 6'(i)) + w_ext[i];
      t2_c[i] = big_sigma0(st_rnd[i][0])
              + ((st_rnd[i][0] & st_rnd[i][1]) ^ (st_rnd[i][0] & st_rnd[i][2])
                 ^ (st_rnd[i][1] & st_rnd[i][2]));
      st_rnd[i+1][0] = t1_c[i] + t2_c[i];
      st_rnd[i+1][1] = st_rnd[i][0];
      st_rnd[i+1][2] = st_rnd[i][1];
      st_rnd[i+1][3] = st_rnd[i][2];
      st_rnd[i+1][4] = st_rnd[i][3] + t1_c[i];
      st_rnd[i+1][5] = st_rnd[i][4];
      st_rnd[i+1][6] = st_rnd[i][5];
      st_rnd[i+1][7] = st_rnd[i][6];
    end
  end

  // Register stage: FSM, working state, schedule window and chaining values
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      t_reg        <= '0;
      mode_reg     <= 1'b0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_reg[i]  <= '0;
        st_reg[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init || next) begin
            if (init) begin
              mode_reg <= mode;
              for (int i = 0; i < 8; i++) begin
                h_reg[i]  <= mode ? IV224[i] : IV256[i];
                st_reg[i] <= mode ? IV224[i] : IV256[i];
              end
            end else begin
              for (int i = 0; i < 8; i++) st_reg[i] <= h_reg[i];
            end
            for (int i = 0; i < 16; i++) w_reg[i] <= block[511-32*i -: 32];
            t_reg        <= '0;
            digest_valid <= 1'b0;
            state        <= ROUNDS;
          end
        end
        ROUNDS: begin
          for (int i = 0; i < 8; i++)  st_reg[i] <= st_rnd[UNROLL][i];
          for (int i = 0; i < 16; i++) w_reg[i]  <= w_ext[i+UNROLL];
          t_reg <= t_reg + T_STEP;
          if (t_reg == T_LAST) state <= DONE;
        end
        DONE: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + st_reg[i];
          digest_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign digest = {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5],
                   h_reg[6], mode_reg ? 32'h0 : h_reg[7]};

endmodule

// File: doc/sha2_unrolled_core.md
# sha2_unrolled_core

Parametrised successor to the single-round SHA-256 compression core. It computes SHA-256 or SHA-224 over caller-padded 512-bit blocks and performs UNROLL rounds per clock cycle. It has its own multi-word message schedule and reuses the existing combinational round-constant ROM, one instance per unrolled round. It sits below the message-padding and bus-interface logic, which supplies whole blocks and the init/next strobes.

## Interface
- UNROLL, 1, rounds per cycle; legal values are 1, 2 or 4. Any other value is an elaboration error.
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- init  input  1  start the first block of a new message. Sampled only when ready=1.
- next  input  1  start a chained block. Sampled only when ready=1.
- mode  input  1  0=SHA-256, 1=SHA-224. Sampled only on an accepted init.
- block  input  512  message block; block[511:480] is W0 (big-endian words). Sampled only on the accepting edge.
- ready  output  1  high exactly while in IDLE.
- digest  output  256  {H0..H7} in SHA-256 mode; {H0..H6, 32'h0} in SHA-224 mode.
- digest_valid  output  1  set when a block completes; cleared when the next block is accepted.

## Operation
- FSM states: IDLE, ROUNDS, DONE.
- **IDLE → ROUNDS** on an edge with init|next=1.
  - init has priority; a simultaneous next is ignored.
  - On init: H0..H7 and a..h load the IV for the sampled mode; the mode register latches.
  - SHA-256 IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - On next: a..h load H0..H7; the mode register is unchanged.
  - On either: the W window (16×32) loads block, round counter t resets to 0, digest_valid clears.
- **ROUNDS**:
  - Each edge applies rounds t..t+UNROLL-1 as a chained combinational cascade: T1 = h+Σ1(e)+Ch(e,f,g)+K[t+i]+W[t+i], T2 = Σ0(a)+Maj(a,b,c).
  - W[t] for t<16 is taken from the block. For t≥16, W[t] = σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
  - The window shifts by UNROLL words per edge and produces UNROLL new words per edge.
  - t is 6 bits and increments by UNROLL each edge.
  - When t = 64−UNROLL, the next state is DONE.
- **DONE**: one edge. Hi ← Hi + state word i for all eight words; digest_valid←1; next state IDLE.
- All arithmetic is modulo 2^32 with carries discarded. t wraps to 0 at its final increment (value unused).
- init/next while ready=0 are ignored and have no side effects. mode changes while busy have no effect.
- next after reset without an intervening init chains from H=0. This is defined, not an error; a correct hash is the caller's responsibility.

## Timing
- Let N = 64/UNROLL. Accepting edge E0.
- ROUNDS occupies edges E1..EN; DONE occupies edge E(N+1).
- digest_valid=1 and ready=1 in the cycle after E(N+1).
- Total latency from accept to digest_valid: N+1 edges; 65/33/17 for UNROLL 1/2/4.
- Back-to-back: a new init/next may be sampled in the first ready cycle. That edge clears digest_valid, so digest_valid is high for one cycle minimum.
- digest is valid whenever digest_valid=1 and holds until the next accepted command. Between commands it shows the raw H registers.
- Reset (reset_n=0 at an edge), including mid-ROUNDS or in DONE:
  - Next cycle: FSM=IDLE, ready=1, digest_valid=0, digest=0.
  - All internal registers cleared (a..h, H, W, t, mode=SHA-256).
  - init/next on a reset edge are ignored.

## Test plan
1. SHA-256 "abc", UNROLL=1.
   - Stimulus: init with block 61626380_00…00_00000018.
   - Response: digest_valid exactly 65 edges after accept; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Same stimulus, UNROLL=2 and 4 → identical digest; latency 33 and 17 edges; ready low throughout processing.
3. SHA-224 "abc", mode=1, all UNROLL values → digest = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
4. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
   - Stimulus: init block 1, next block 2 in the first ready cycle; toggle mode before the next.
   - Response: digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and mode toggle has no effect.
5. Command handling.
   - Pulse init and next mid-ROUNDS → ignored; digest unchanged from case 1.
   - Assert init+next together in IDLE → result equals init-only result.
6. Reset recovery.
   - Stimulus: reset_n low for one edge at t=20.
   - Response: next cycle ready=1, digest_valid=0, digest=0. A following "abc" init produces the case-1 digest with nominal latency.
